// File: rtl/sync_pkg.sv
// Shared constants and helpers for the synchronizer bank.
//   MIN_STAGES : smallest legal synchronizer chain depth
//   MIN_FILTER : smallest legal stability filter length (1 = pass-through)
//   cnt_width  : width of the per-channel stability counter
package sync_pkg;

  localparam int MIN_STAGES = 2;
  localparam int MIN_FILTER = 1;

  // The counter only has to reach FILTER-1, so clog2(FILTER+1) is enough.
  // Keep at least one bit so FILTER=1 still gets a legal vector.
  function automatic int cnt_width(input int filter);
    int w;
    w = $clog2(filter + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sync_edge_ch.sv
// One synchronizer channel: flop chain, stability filter, registered level
// and rise/fall pulse decode.
//   clk        : clock
//   reset      : synchronous, active-high reset
//   async_in   : asynchronous level input
//   level_out  : synchronized, filtered level
//   rise_pulse : one-cycle pulse when level_out goes 0->1
//   fall_pulse : one-cycle pulse when level_out goes 1->0
module sync_edge_ch
  import sync_pkg::*;
#(
  parameter int   STAGES    = 2,
  parameter int   FILTER    = 1,
  parameter logic RESET_BIT = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic level_out,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int              CNT_W    = cnt_width(FILTER);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER - 1);

  logic [STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              level_q, level_d;
  logic              prev_q;
  logic              synced;

  assign synced = sync_q[STAGES-1];

  always_comb begin
    // Plain shift: nothing combinational between chain flops.
    sync_d  = {sync_q[STAGES-2:0], async_in};
    cnt_d   = cnt_q;
    level_d = level_q;
    if (synced == level_q) begin
      // Any return to the accepted level discards a partial run (glitch).
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = synced;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= {STAGES{RESET_BIT}};
      cnt_q   <= '0;
      level_q <= RESET_BIT;
      prev_q  <= RESET_BIT;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      prev_q  <= level_q;
    end
  end

  // Decoded from two flops only, so the pulses cannot glitch. Resetting
  // prev together with level keeps reset itself from producing a pulse.
  assign level_out  = level_q;
  assign rise_pulse = level_q & ~prev_q;
  assign fall_pulse = ~level_q & prev_q;

endmodule

// File: rtl/sync_edge_bank.sv
// Bank of WIDTH independent single-bit synchronizers with glitch filter and
// edge detection. Not for multi-bit buses that must stay coherent.
//   clk        : sole clock, rising edge
//   reset      : synchronous, active-high reset
//   async_in   : asynchronous level inputs [WIDTH]
//   level_out  : synchronized, filtered levels [WIDTH]
//   rise_pulse : per-channel one-cycle 0->1 pulse [WIDTH]
//   fall_pulse : per-channel one-cycle 1->0 pulse [WIDTH]
//   any_change : OR of every rise and fall pulse
module sync_edge_bank
  import sync_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter int               STAGES    = 2,
  parameter int               FILTER    = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             any_change
);

  if (WIDTH < 1) begin : g_err_width
    $error("sync_edge_bank: WIDTH must be >= 1");
  end
  if (STAGES < MIN_STAGES) begin : g_err_stages
    $error("sync_edge_bank: STAGES must be >= %0d", MIN_STAGES);
  end
  if (FILTER < MIN_FILTER) begin : g_err_filter
    $error("sync_edge_bank: FILTER must be >= %0d", MIN_FILTER);
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    sync_edge_ch #(
      .STAGES    (STAGES),
      .FILTER    (FILTER),
      .RESET_BIT (RESET_VAL[i])
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .async_in   (async_in[i]),
      .level_out  (level_out[i]),
      .rise_pulse (rise_pulse[i]),
      .fall_pulse (fall_pulse[i])
    );
  end

  assign any_change = |(rise_pulse | fall_pulse);

endmodule

// File: tb/tb_sync_edge_bank.sv
module tb_sync_edge_bank;

  logic       clk = 1'b0;
  logic       reset_a, reset_b;
  logic [3:0] in_a, in_b;
  logic [3:0] lvl_a, rise_a, fall_a, lvl_b, rise_b, fall_b;
  logic       any_a, any_b;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    int         cyc;
    bit         dut;   // 0: config A, 1: config B
    string      tag;
    logic [3:0] lvl;
    logic [3:0] rise;
    logic [3:0] fall;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // A: STAGES=2 FILTER=3 RESET_VAL=0000
  sync_edge_bank #(.WIDTH(4), .STAGES(2), .FILTER(3), .RESET_VAL(4'b0000)) u_dut_a (
    .clk(clk), .reset(reset_a), .async_in(in_a),
    .level_out(lvl_a), .rise_pulse(rise_a), .fall_pulse(fall_a), .any_change(any_a)
  );

  // B: STAGES=3 FILTER=1 RESET_VAL=0101
  sync_edge_bank #(.WIDTH(4), .STAGES(3), .FILTER(1), .RESET_VAL(4'b0101)) u_dut_b (
    .clk(clk), .reset(reset_b), .async_in(in_b),
    .level_out(lvl_b), .rise_pulse(rise_b), .fall_pulse(fall_b), .any_change(any_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Queue n expectations for cycles cyc+off .. cyc+off+n-1, kept sorted by cycle.
  task automatic exp_span(input bit dut, input string tag, input int off, input int n,
                          input logic [3:0] lvl, input logic [3:0] rise, input logic [3:0] fall);
    for (int k = 0; k < n; k++) begin
      exp_t e;
      int   idx;
      e.cyc  = cyc + off + k;
      e.dut  = dut;
      e.tag  = tag;
      e.lvl  = lvl;
      e.rise = rise;
      e.fall = fall;
      idx = sb.size();
      while (idx > 0 && sb[idx-1].cyc > e.cyc) idx--;
      sb.insert(idx, e);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Compare everything due this cycle, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc < cyc) check_eq({e.tag, "_late"}, cyc, e.cyc);
      if (!e.dut) begin
        check_eq($sformatf("%s_lvl@%0d", e.tag, cyc),  lvl_a,  e.lvl);
        check_eq($sformatf("%s_rise@%0d", e.tag, cyc), rise_a, e.rise);
        check_eq($sformatf("%s_fall@%0d", e.tag, cyc), fall_a, e.fall);
        check_eq($sformatf("%s_any@%0d", e.tag, cyc),  any_a,  |(e.rise | e.fall));
      end else begin
        check_eq($sformatf("%s_lvl@%0d", e.tag, cyc),  lvl_b,  e.lvl);
        check_eq($sformatf("%s_rise@%0d", e.tag, cyc), rise_b, e.rise);
        check_eq($sformatf("%s_fall@%0d", e.tag, cyc), fall_b, e.fall);
        check_eq($sformatf("%s_any@%0d", e.tag, cyc),  any_b,  |(e.rise | e.fall));
      end
    end
  end

  initial begin
    reset_a = 1'b1;
    reset_b = 1'b1;
    in_a    = 4'b1111;
    in_b    = 4'b0000;

    // 1: reset with inputs high, then all channels rise together after 5 edges.
    exp_span(0, "t1_rst", 1, 3, 4'b0000, 4'b0000, 4'b0000);
    exp_span(1, "t6_rst", 1, 3, 4'b0101, 4'b0000, 4'b0000);
    tick(3);
    reset_a = 1'b0;
    exp_span(0, "t1_wait", 1, 4, 4'b0000, 4'b0000, 4'b0000);
    exp_span(0, "t1_rise", 5, 1, 4'b1111, 4'b1111, 4'b0000);
    exp_span(0, "t1_hold", 6, 2, 4'b1111, 4'b0000, 4'b0000);
    tick(7);

    // Return to all-low.
    in_a = 4'b0000;
    exp_span(0, "t1b_wait", 1, 4, 4'b1111, 4'b0000, 4'b0000);
    exp_span(0, "t1b_fall", 5, 1, 4'b0000, 4'b0000, 4'b1111);
    exp_span(0, "t1b_hold", 6, 3, 4'b0000, 4'b0000, 4'b0000);
    tick(8);

    // 2: single channel rise.
    in_a = 4'b0001;
    exp_span(0, "t2_wait", 1, 4, 4'b0000, 4'b0000, 4'b0000);
    exp_span(0, "t2_rise", 5, 1, 4'b0001, 4'b0001, 4'b0000);
    exp_span(0, "t2_hold", 6, 3, 4'b0001, 4'b0000, 4'b0000);
    tick(8);

    // 3a: 2-cycle glitch on channel 1 is rejected.
    in_a = 4'b0011;
    exp_span(0, "t3_glitch", 1, 10, 4'b0001, 4'b0000, 4'b0000);
    tick(2);
    in_a = 4'b0001;
    tick(8);

    // 3b: 3-cycle high on channel 1 gets through: rise, fall 3 cycles later.
    in_a = 4'b0011;
    exp_span(0, "t3_wait", 1, 4, 4'b0001, 4'b0000, 4'b0000);
    exp_span(0, "t3_rise", 5, 1, 4'b0011, 4'b0010, 4'b0000);
    exp_span(0, "t3_high", 6, 2, 4'b0011, 4'b0000, 4'b0000);
    exp_span(0, "t3_fall", 8, 1, 4'b0001, 4'b0000, 4'b0010);
    exp_span(0, "t3_low",  9, 2, 4'b0001, 4'b0000, 4'b0000);
    tick(3);
    in_a = 4'b0001;
    tick(7);

    // 4: rise on ch3 and fall on ch0 in the same cycle.
    in_a = 4'b1000;
    exp_span(0, "t4_wait", 1, 4, 4'b0001, 4'b0000, 4'b0000);
    exp_span(0, "t4_both", 5, 1, 4'b1000, 4'b1000, 4'b0001);
    exp_span(0, "t4_hold", 6, 2, 4'b1000, 4'b0000, 4'b0000);
    tick(8);

    // 5: bring all high, then reset mid-operation.
    in_a = 4'b1111;
    exp_span(0, "t5_wait", 1, 4, 4'b1000, 4'b0000, 4'b0000);
    exp_span(0, "t5_rise", 5, 1, 4'b1111, 4'b0111, 4'b0000);
    exp_span(0, "t5_hold", 6, 2, 4'b1111, 4'b0000, 4'b0000);
    tick(8);
    reset_a = 1'b1;
    exp_span(0, "t5_rst", 1, 1, 4'b0000, 4'b0000, 4'b0000);
    tick(1);
    reset_a = 1'b0;
    exp_span(0, "t5_wait2", 1, 4, 4'b0000, 4'b0000, 4'b0000);
    exp_span(0, "t5_rise2", 5, 1, 4'b1111, 4'b1111, 4'b0000);
    exp_span(0, "t5_hold2", 6, 2, 4'b1111, 4'b0000, 4'b0000);
    tick(8);

    // 6: config B, non-zero reset value, 3 stages, no filtering.
    exp_span(1, "t6_rst2", 1, 1, 4'b0101, 4'b0000, 4'b0000);
    tick(1);
    reset_b = 1'b0;
    exp_span(1, "t6_wait", 1, 3, 4'b0101, 4'b0000, 4'b0000);
    exp_span(1, "t6_fall", 4, 1, 4'b0000, 4'b0000, 4'b0101);
    exp_span(1, "t6_hold", 5, 2, 4'b0000, 4'b0000, 4'b0000);
    tick(7);
    in_b = 4'b0010;
    exp_span(1, "t6p_wait", 1, 3, 4'b0000, 4'b0000, 4'b0000);
    exp_span(1, "t6p_rise", 4, 1, 4'b0010, 4'b0010, 4'b0000);
    exp_span(1, "t6p_fall", 5, 1, 4'b0000, 4'b0000, 4'b0010);
    exp_span(1, "t6p_hold", 6, 2, 4'b0000, 4'b0000, 4'b0000);
    tick(1);
    in_b = 4'b0000;
    tick(9);

    check_eq("sb_drain", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
